// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan codes, snake direction encoding, frame FSM
// states and the odd-parity helper. Used by ps2_rx_frame and ps2_arrow_decoder.
package ps2_pkg;

    // Scan codes of interest (set 2)
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Direction encoding shared with the snake control FSM
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    // Device-to-host frame FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data ^ par) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_arrow_decoder_if.sv
// PS/2 pin inputs and decoded keyboard outputs of ps2_arrow_decoder.
// master: the decoder (samples pins, drives results); slave: pin source / consumer.
interface ps2_arrow_decoder_if;

    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic [1:0] dir;
    logic       dir_valid;

    modport master (
        input  ps2_clk, ps2_dat,
        output code, code_valid, frame_err,
        output key_left, key_right, key_up, key_down,
        output dir, dir_valid
    );

    modport slave (
        output ps2_clk, ps2_dat,
        input  code, code_valid, frame_err,
        input  key_left, key_right, key_up, key_down,
        input  dir, dir_valid
    );

endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: pin synchronizers, PS2_CLK falling-edge detector and
// the 11-bit frame FSM. Emits a good byte with a one-cycle code_valid, or a
// one-cycle frame_err on parity/stop failure.
// Optional PS2_TIMEOUT_EN: abandon a partial frame after TIMEOUT_CYCLES idle clks.
import ps2_pkg::*;

module ps2_rx_frame #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_code,
    output logic       o_code_valid,
    output logic       o_frame_err
);

    // The idle counter is 16 bits wide
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("ps2_rx_frame: TIMEOUT_CYCLES must be in 2..65536");
    end

    logic [1:0]   r_clk_sync;
    logic [1:0]   r_dat_sync;
    logic         r_clk_prev;
    logic         w_fe;
    logic         w_dat;

    frame_state_t r_state;
    logic [7:0]   r_shreg;
    logic [2:0]   r_bit_cnt;
    logic         r_par_ok;
    logic [7:0]   r_code;
    logic         r_code_valid;
    logic         r_frame_err;
    logic         w_timeout;

    // Two-flop synchronizers plus previous-sample register; lines idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fe  = r_clk_prev & ~r_clk_sync[1];
    assign w_dat = r_dat_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_idle_cnt;

    // Idle counter: cleared on every falling edge and while idle, saturates at the limit
    always_ff @(posedge clk) begin
        if (reset || w_fe || r_state == ST_IDLE) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TIMEOUT_LAST) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_idle_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Frame FSM: advances on PS2_CLK falling edges; a timeout only acts without an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_par_ok     <= 1'b0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fe) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shreg <= {w_dat, r_shreg[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shreg, w_dat);
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_dat && r_par_ok) begin
                            r_code       <= r_shreg;
                            r_code_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder for the snake game. Receives frames through
// ps2_rx_frame and decodes E0-prefixed arrow make/break sequences into
// held key levels and a 2-bit direction (0 left, 1 right, 2 up, 3 down).
// Optional PS2_TIMEOUT_EN enables the partial-frame timeout in ps2_rx_frame.
import ps2_pkg::*;

module ps2_arrow_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [1:0]  DIR_RESET      = 2'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_arrow_decoder_if.master   bus
);

    logic [7:0] w_code;
    logic       w_code_valid;
    logic       w_frame_err;

    logic       r_ext;
    logic       r_brk;
    logic [3:0] r_keys;       // indexed by direction code
    logic [1:0] r_dir;
    logic       r_dir_valid;

    logic       w_is_arrow;
    logic [1:0] w_arrow_dir;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_dat    (bus.ps2_dat),
        .o_code       (w_code),
        .o_code_valid (w_code_valid),
        .o_frame_err  (w_frame_err)
    );

    // Map an arrow scan code to its direction
    always_comb begin
        w_is_arrow  = 1'b0;
        w_arrow_dir = DIR_LEFT;
        case (w_code)
            SC_LEFT:  begin w_is_arrow = 1'b1; w_arrow_dir = DIR_LEFT;  end
            SC_RIGHT: begin w_is_arrow = 1'b1; w_arrow_dir = DIR_RIGHT; end
            SC_UP:    begin w_is_arrow = 1'b1; w_arrow_dir = DIR_UP;    end
            SC_DOWN:  begin w_is_arrow = 1'b1; w_arrow_dir = DIR_DOWN;  end
            default:  ;
        endcase
    end

    // Prefix tracking and key/direction updates on each received byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_keys      <= '0;
            r_dir       <= DIR_RESET;
            r_dir_valid <= 1'b0;
        end else begin
            r_dir_valid <= 1'b0;
            if (w_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_code_valid) begin
                if (w_code == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_code == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_ext && w_is_arrow) begin
                        r_keys[w_arrow_dir] <= !r_brk;
                        if (!r_brk) begin
                            r_dir       <= w_arrow_dir;
                            r_dir_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.code       = w_code;
    assign bus.code_valid = w_code_valid;
    assign bus.frame_err  = w_frame_err;
    assign bus.key_left   = r_keys[DIR_LEFT];
    assign bus.key_right  = r_keys[DIR_RIGHT];
    assign bus.key_up     = r_keys[DIR_UP];
    assign bus.key_down   = r_keys[DIR_DOWN];
    assign bus.dir        = r_dir;
    assign bus.dir_valid  = r_dir_valid;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder: drives PS/2 frames bit by bit and
// checks pulse counts, held keys, direction and code against hand values.
// The timeout scenario is included when PS2_TIMEOUT_EN is defined.
module tb_ps2_arrow_decoder;

    localparam int HALF = 10;   // PS/2 half-period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;

    ps2_arrow_decoder_if bus ();

    ps2_arrow_decoder #(
        .TIMEOUT_CYCLES (50000),
        .DIR_RESET      (2'd1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int n_cv = 0;
    int n_fe = 0;
    int n_dv = 0;
    int b_cv, b_fe, b_dv;

    // Count high cycles of each pulse output
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.code_valid) n_cv++;
            if (bus.frame_err)  n_fe++;
            if (bus.dir_valid)  n_dv++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        @(negedge clk);
        b_cv = n_cv;
        b_fe = n_fe;
        b_dv = n_dv;
    endtask

    function automatic logic [3:0] keys();
        return {bus.key_left, bus.key_right, bus.key_up, bus.key_down};
    endfunction

    task automatic ps2_bit(input logic b);
        bus.ps2_dat = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        bus.ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] data);
        send_frame(data, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        do_reset();

        // Reset values
        chk("rst_code", bus.code, 8'h00);
        chk("rst_cv", bus.code_valid, 1'b0);
        chk("rst_fe", bus.frame_err, 1'b0);
        chk("rst_keys", keys(), 4'b0000);
        chk("rst_dir", bus.dir, 2'd1);
        chk("rst_dv", bus.dir_valid, 1'b0);

        // Up make
        mark();
        send(8'hE0); send(8'h75);
        chk("up_make_dv", n_dv - b_dv, 1);
        chk("up_make_dir", bus.dir, 2'd2);
        chk("up_make_keys", keys(), 4'b0010);
        chk("up_make_cv", n_cv - b_cv, 2);
        chk("up_make_fe", n_fe - b_fe, 0);
        chk("up_make_code", bus.code, 8'h75);

        // Left make while up held, then up break
        mark();
        send(8'hE0); send(8'h6B);
        chk("left_make_dir", bus.dir, 2'd0);
        chk("two_held_keys", keys(), 4'b1010);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_brk_keys", keys(), 4'b1000);
        chk("up_brk_dir", bus.dir, 2'd0);
        chk("up_brk_dv", n_dv - b_dv, 1);
        chk("up_brk_cv", n_cv - b_cv, 5);

        // Typematic repeat of left
        mark();
        send(8'hE0); send(8'h6B);
        chk("repeat_dv", n_dv - b_dv, 1);
        chk("repeat_dir", bus.dir, 2'd0);

        // Bad parity; E0 prefix is dropped by the error
        do_reset();
        mark();
        send(8'hE0);
        send_frame(8'h6B, 1'b1, 1'b0);
        chk("par_fe", n_fe - b_fe, 1);
        chk("par_cv", n_cv - b_cv, 1);
        chk("par_dir", bus.dir, 2'd1);
        chk("par_code", bus.code, 8'hE0);
        send(8'h74);
        chk("par_noext_dv", n_dv - b_dv, 0);
        chk("par_noext_keys", keys(), 4'b0000);

        // Stop bit 0, then good right make
        mark();
        send_frame(8'h74, 1'b0, 1'b1);
        chk("stop_fe", n_fe - b_fe, 1);
        chk("stop_cv", n_cv - b_cv, 0);
        send(8'hE0); send(8'h74);
        chk("right_dir", bus.dir, 2'd1);
        chk("right_keys", keys(), 4'b0100);
        chk("right_dv", n_dv - b_dv, 1);

`ifdef PS2_TIMEOUT_EN
        // Partial frame abandoned by timeout
        mark();
        send(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        bus.ps2_dat = 1'b1;
        repeat (50020) @(negedge clk);
        chk("to_fe", n_fe - b_fe, 1);
        send(8'h6B);
        chk("to_noext_dv", n_dv - b_dv, 0);
        send(8'hE0); send(8'h6B);
        chk("to_left_dir", bus.dir, 2'd0);
        chk("to_left_dv", n_dv - b_dv, 1);
`endif

        // Non-extended code
        mark();
        send(8'h1C);
        chk("nx_code", bus.code, 8'h1C);
        chk("nx_cv", n_cv - b_cv, 1);
        chk("nx_dv", n_dv - b_dv, 0);

        // Reset mid-frame
        send(8'hE0); send(8'h75);
        ps2_bit(1'b0);
        ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        bus.ps2_dat = 1'b1;
        do_reset();
        chk("mid_rst_code", bus.code, 8'h00);
        chk("mid_rst_keys", keys(), 4'b0000);
        chk("mid_rst_dir", bus.dir, 2'd1);
        chk("mid_rst_pulses", {bus.code_valid, bus.frame_err, bus.dir_valid}, 3'b000);
        mark();
        send(8'hE0); send(8'h72);
        chk("down_dir", bus.dir, 2'd3);
        chk("down_keys", keys(), 4'b0001);
        chk("down_code", bus.code, 8'h72);
        chk("down_cv", n_cv - b_cv, 2);
        chk("down_fe", n_fe - b_fe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
